// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Words written into the FIFO are framed as start, data (LSB first), optional parity and stop bits.
// Back-to-back frames are sent with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned TimerW = $clog2(BAUD_DIV);
  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int unsigned BitW   = 4;

  localparam logic [AddrW:0]    FullCnt  = (AddrW+1)'(FIFO_DEPTH);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(BAUD_DIV - 1);
  localparam logic [BitW-1:0]   DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]   StopLast = BitW'(STOP_BITS - 1);
  localparam logic              OddPar   = (PARITY == 2);
  localparam logic              HasPar   = (PARITY != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]       count_q, count_d;
  logic                 overflow_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Transmitter state
  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 bit_done;

  assign full     = (count_q == FullCnt);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != StIdle);

  // A write while full only fits if the transmitter frees a slot on the same edge.
  assign push = wr_en && (!full || pop);
  assign head = mem[rd_ptr_q];

  // Occupancy next state from the push/pop pair
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= wr_en && !push;
    end
  end

  assign bit_done = (timer_q == BitLast);

  // Frame sequencing: next state, bit timing, serial output and FIFO pop
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        tx_d    = 1'b1;
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          timer_d = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (HasPar) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          timer_d = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // Popping loads the local shift register and starts a fresh frame with the timer cleared.
    if (pop) begin
      state_d  = StStart;
      timer_d  = '0;
      bit_d    = '0;
      tx_d     = 1'b0;
      shift_d  = head;
      parity_d = (^head) ^ OddPar;
    end
  end

  // Transmitter state registers; tx idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three configurations, a vector table of single frames,
// hand-written multi-cycle sequences and randomized traffic against a queue-based frame model.
module tb_uart_tx_fifo;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] we_v;
  logic [7:0] wd0, wd1;
  logic [6:0] wd2;
  logic       tx0, tx1, tx2, busy0, busy1, busy2;
  logic       full0, full1, full2, empty0, empty1, empty2, ovf0, ovf1, ovf2;
  logic [2:0] cnt0, cnt1, cnt2;

  // DUT 0: even parity, DUT 1: odd parity, DUT 2: 7 data bits, no parity, 2 stop bits
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rst(rst_v[0]), .wr_data(wd0), .wr_en(we_v[0]), .full(full0), .empty(empty0),
    .count(cnt0), .overflow(ovf0), .tx(tx0), .tx_busy(busy0)
  );
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst_v[1]), .wr_data(wd1), .wr_en(we_v[1]), .full(full1), .empty(empty1),
    .count(cnt1), .overflow(ovf1), .tx(tx1), .tx_busy(busy1)
  );
  uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s6 (
    .clk(clk), .rst(rst_v[2]), .wr_data(wd2), .wr_en(we_v[2]), .full(full2), .empty(empty2),
    .count(cnt2), .overflow(ovf2), .tx(tx2), .tx_busy(busy2)
  );

  // Observation word of the selected DUT: {tx, busy, full, empty, overflow, count[2:0]}
  int sel = 0;
  logic [7:0] o0, o1, o2, obs;
  assign o0  = {tx0, busy0, full0, empty0, ovf0, cnt0};
  assign o1  = {tx1, busy1, full1, empty1, ovf1, cnt1};
  assign o2  = {tx2, busy2, full2, empty2, ovf2, cnt2};
  assign obs = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;

  localparam logic [7:0] ResetObs = 8'b1001_0000;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the expanded bit list of the frame on the line.
  logic [8:0] mq[$];
  bit         mbusy, mov;
  int         mt, mlen;
  bit         mframe[16];
  int         cdb, cpar, csb;
  logic       cur_we;
  logic [8:0] cur_wd;

  task automatic model_reset();
    mq.delete();
    mbusy = 0;
    mov   = 0;
    mt    = 0;
    mlen  = 0;
  endtask

  task automatic load_frame(input logic [8:0] w);
    int n;
    bit p;
    p = 0;
    mframe[0] = 0;
    n = 1;
    for (int i = 0; i < cdb; i++) begin
      mframe[n] = w[i];
      p ^= w[i];
      n++;
    end
    if (cpar != 0) begin
      mframe[n] = (cpar == 1) ? p : !p;
      n++;
    end
    for (int i = 0; i < csb; i++) begin
      mframe[n] = 1;
      n++;
    end
    mlen = n * BAUD;
  endtask

  task automatic model_step();
    bit ending, can_pop, was_full, acc;
    ending   = mbusy && (mt == mlen - 1);
    can_pop  = (!mbusy || ending) && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    acc      = cur_we && (!was_full || can_pop);
    mov      = cur_we && !acc;
    if (can_pop) begin
      load_frame(mq.pop_front());
      mbusy = 1;
      mt    = 0;
    end else if (ending) begin
      mbusy = 0;
      mt    = 0;
    end else if (mbusy) begin
      mt++;
    end
    if (acc) mq.push_back(cur_wd);
  endtask

  function automatic logic [7:0] model_obs();
    int   sz;
    logic t;
    sz = mq.size();
    t  = mbusy ? mframe[mt / BAUD] : 1'b1;
    return {t, mbusy, sz == DEPTH, sz == 0, mov, 3'(sz)};
  endfunction

  task automatic drive(input logic we, input logic [8:0] w);
    logic [8:0] mask;
    mask    = 9'((1 << cdb) - 1);
    we_v    = '0;
    we_v[sel] = we;
    case (sel)
      0:       wd0 = w[7:0];
      1:       wd1 = w[7:0];
      default: wd2 = w[6:0];
    endcase
    cur_we = we;
    cur_wd = w & mask;
  endtask

  // One clock: model advances on the edge, DUT is compared 1 time unit later.
  task automatic cycle(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, obs, model_obs());
  endtask

  task automatic do_reset(input int k);
    sel  = k;
    cdb  = (k == 2) ? 7 : 8;
    cpar = (k == 0) ? 1 : (k == 1) ? 2 : 0;
    csb  = (k == 2) ? 2 : 1;
    drive(1'b0, 9'h0);
    rst_v[k] = 1'b1;
    model_reset();
    cycle("reset hold");
    check("reset state", obs, ResetObs);
    rst_v[k] = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    drive(1'b0, 9'h0);
    while ((obs[6] || !obs[4]) && g < 800) begin
      cycle(name);
      g++;
    end
    check({name, " drained"}, {obs[7:6], obs[4]}, 3'b101);
  endtask

  typedef struct packed {
    logic [1:0]  sel;
    logic [8:0]  word;
    logic [11:0] frame;   // bit i is the i-th bit on the line
    logic [3:0]  nbits;
  } vec_t;

  vec_t tbl[8];
  int   s3_cnt[6]  = '{1, 1, 2, 3, 4, 4};
  int   s3_full[6] = '{0, 0, 0, 0, 1, 1};
  int   s3_ovf[6]  = '{0, 0, 0, 0, 0, 1};
  int   busy_cnt, rises, rate, g;
  bit   prev_busy;

  task automatic track_busy();
    if (obs[6]) busy_cnt++;
    if (obs[6] && !prev_busy) rises++;
    prev_busy = obs[6];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{2'd0, 9'h055, 12'({1'b1, 1'b0, 8'h55, 1'b0}), 4'd11};
    tbl[1] = '{2'd1, 9'h000, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 4'd11};
    tbl[2] = '{2'd2, 9'h041, 12'({1'b1, 1'b1, 7'h41, 1'b0}), 4'd10};
    tbl[3] = '{2'd0, 9'h0A3, 12'({1'b1, 1'b0, 8'hA3, 1'b0}), 4'd11};
    tbl[4] = '{2'd1, 9'h0FF, 12'({1'b1, 1'b1, 8'hFF, 1'b0}), 4'd11};
    tbl[5] = '{2'd0, 9'h001, 12'({1'b1, 1'b1, 8'h01, 1'b0}), 4'd11};
    tbl[6] = '{2'd1, 9'h080, 12'({1'b1, 1'b0, 8'h80, 1'b0}), 4'd11};
    tbl[7] = '{2'd2, 9'h07F, 12'({1'b1, 1'b1, 7'h7F, 1'b0}), 4'd10};

    rst_v = '0;
    we_v  = '0;
    wd0   = '0;
    wd1   = '0;
    wd2   = '0;
    cdb   = 8;
    #1 rst_v = 3'b111;
    #2;
    check("async reset dut0", o0, ResetObs);
    check("async reset dut1", o1, ResetObs);
    check("async reset dut2", o2, ResetObs);
    @(posedge clk);
    @(posedge clk);
    #1 rst_v = 3'b000;

    // Single frames: exact bit sequence, 4 cycles per bit, tx low from the edge after the write.
    for (int v = 0; v < 8; v++) begin
      do_reset(int'(tbl[v].sel));
      drive(1'b1, tbl[v].word);
      cycle("tbl write");
      drive(1'b0, 9'h0);
      check($sformatf("tbl%0d queued", v), {obs[7:6], obs[4], obs[2:0]}, {3'b100, 3'd1});
      for (int b = 0; b < int'(tbl[v].nbits); b++) begin
        for (int c = 0; c < BAUD; c++) begin
          cycle("tbl frame");
          check($sformatf("tbl%0d bit%0d", v, b), obs[7:6], {tbl[v].frame[b], 1'b1});
        end
      end
      cycle("tbl end");
      check($sformatf("tbl%0d idle", v), {obs[7:6], obs[4]}, 3'b101);
    end

    // Six consecutive writes: fill to 4, drop the sixth, five frames back to back.
    do_reset(0);
    busy_cnt  = 0;
    rises     = 0;
    prev_busy = 0;
    for (int e = 0; e < 6; e++) begin
      drive(1'b1, 9'h0A0 + 9'(e));
      cycle("s3 write");
      check($sformatf("s3 occupancy e%0d", e), {obs[5], obs[3], obs[2:0]},
            {1'(s3_full[e]), 1'(s3_ovf[e]), 3'(s3_cnt[e])});
      track_busy();
    end
    drive(1'b0, 9'h0);
    cycle("s3 after");
    check("s3 overflow one cycle", obs[3], 1'b0);
    track_busy();
    g = 0;
    while (obs[6] && g < 400) begin
      cycle("s3 run");
      track_busy();
      g++;
    end
    check("s3 busy cycles", busy_cnt, 220);
    check("s3 busy continuous", rises, 1);
    check("s3 empty after", obs[4], 1'b1);

    // Write while full on the exact edge that pops: accepted, no overflow.
    do_reset(0);
    for (int e = 0; e < 5; e++) begin
      drive(1'b1, 9'h010 + 9'(e));
      cycle("s4 fill");
    end
    check("s4 full", {obs[5], obs[2:0]}, {1'b1, 3'd4});
    drive(1'b0, 9'h0);
    for (int e = 5; e < 45; e++) cycle("s4 wait");
    drive(1'b1, 9'h0C6);
    cycle("s4 write at pop");
    check("s4 accepted", {obs[5], obs[3], obs[2:0]}, {1'b1, 1'b0, 3'd4});
    drive(1'b0, 9'h0);
    cycle("s4 next");
    check("s4 no overflow", obs[3], 1'b0);
    drain("s4");

    // Reset mid data bit 3 with two words queued.
    do_reset(0);
    drive(1'b1, 9'h0F0); cycle("s5 write");
    drive(1'b1, 9'h033); cycle("s5 write");
    drive(1'b1, 9'h0CC); cycle("s5 write");
    drive(1'b0, 9'h0);
    for (int e = 3; e <= 18; e++) cycle("s5 run");
    check("s5 before reset", {obs[7:6], obs[2:0]}, {2'b01, 3'd2});
    #2 rst_v[0] = 1'b1;
    #1;
    check("s5 async reset", obs, ResetObs);
    model_reset();
    cycle("s5 in reset");
    rst_v[0] = 1'b0;
    for (int e = 0; e < 60; e++) cycle("s5 quiet");
    check("s5 quiet end", {obs[7:6], obs[4]}, 3'b101);

    // Randomized traffic with varying write density on every configuration.
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      rate = 50;
      for (int c = 0; c < 1500; c++) begin
        if (c % 150 == 0) rate = int'($urandom_range(5, 95));
        drive(int'($urandom_range(0, 99)) < rate, 9'($urandom));
        cycle($sformatf("rand dut%0d", k));
      end
      drain($sformatf("rand dut%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
